// File: rtl/fc_mem_if.sv
// Read port bundle between the MAC engine and its data RAM / weight ROM.
// Master drives the strobe and addresses; slave returns five words.
interface fc_mem_if #(
  parameter int Bit_width = 16
);
  logic                        Read_Enable;
  logic [3:0]                  Read_Width;
  logic [5:0]                  Weight_Addr;
  logic signed [Bit_width-1:0] data_in_0;
  logic signed [Bit_width-1:0] data_in_1;
  logic signed [Bit_width-1:0] data_in_2;
  logic signed [Bit_width-1:0] data_in_3;
  logic signed [Bit_width-1:0] data_in_4;
  logic signed [Bit_width-1:0] weight_in_0;
  logic signed [Bit_width-1:0] weight_in_1;
  logic signed [Bit_width-1:0] weight_in_2;
  logic signed [Bit_width-1:0] weight_in_3;
  logic signed [Bit_width-1:0] weight_in_4;

  modport master (
    output Read_Enable, Read_Width, Weight_Addr,
    input  data_in_0, data_in_1, data_in_2,
    input  data_in_3, data_in_4,
    input  weight_in_0, weight_in_1, weight_in_2,
    input  weight_in_3, weight_in_4
  );

  modport slave (
    input  Read_Enable, Read_Width, Weight_Addr,
    output data_in_0, data_in_1, data_in_2,
    output data_in_3, data_in_4,
    output weight_in_0, weight_in_1, weight_in_2,
    output weight_in_3, weight_in_4
  );
endinterface

// File: rtl/fc_2nd_mac_engine.sv
// Second fully-connected layer: 20-tap fixed-point MAC per neuron,
// four 5-word chunks per neuron, one result per 9 cycles.
module fc_2nd_mac_engine #(
  parameter int Bit_width   = 16,
  parameter int Num_Neurons = 10,
  parameter int Frac_bits   = 8,
  parameter int Use_ReLU    = 0
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic                        start,
  fc_mem_if.master                    mem,
  output logic signed [Bit_width-1:0] result,
  output logic                        result_valid,
  output logic [3:0]                  result_index,
  output logic                        busy,
  output logic                        done
);
  localparam int PW = 2 * Bit_width;
  localparam int AW = 2 * Bit_width + 6;
  localparam logic [3:0] LAST = 4'(Num_Neurons - 1);
  localparam logic signed [AW-1:0] SAT_HI =
    {{(AW-Bit_width+1){1'b0}}, {(Bit_width-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_LO =
    {{(AW-Bit_width+1){1'b1}}, {(Bit_width-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE, READ, MAC, OUT, DONE
  } state_t;

  state_t state, state_nx;
  logic [1:0] chunk;
  logic [3:0] neuron;
  logic signed [AW-1:0] acc, acc_sum, shifted;
  logic signed [Bit_width-1:0] sat, result_nx;
  logic signed [Bit_width-1:0] d [5];
  logic signed [Bit_width-1:0] w [5];

  assign d = '{mem.data_in_0, mem.data_in_1, mem.data_in_2,
               mem.data_in_3, mem.data_in_4};
  assign w = '{mem.weight_in_0, mem.weight_in_1, mem.weight_in_2,
               mem.weight_in_3, mem.weight_in_4};

  assign mem.Read_Enable = (state == READ);
  assign mem.Read_Width  = {chunk, 2'b00} + {2'b00, chunk};
  assign mem.Weight_Addr = {neuron, 2'b00} + {4'b0000, chunk};
  assign result_valid    = (state == OUT);
  assign done            = (state == DONE);
  assign busy            = (state != IDLE);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = READ;
      READ:    state_nx = MAC;
      MAC:     state_nx = (chunk == 2'd3) ? OUT : READ;
      OUT:     state_nx = (neuron == LAST) ? DONE : READ;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Products are full-width and sign-extended into the wide accumulator.
  always_comb begin
    acc_sum = acc;
    for (int k = 0; k < 5; k++)
      acc_sum = acc_sum + AW'(PW'(d[k]) * PW'(w[k]));
  end

  always_comb begin
    shifted = acc_sum >>> Frac_bits;
    sat     = shifted[Bit_width-1:0];
    if (shifted > SAT_HI)
      sat = SAT_HI[Bit_width-1:0];
    else if (shifted < SAT_LO)
      sat = SAT_LO[Bit_width-1:0];
    result_nx = sat;
    if (Use_ReLU != 0 && sat[Bit_width-1])
      result_nx = '0;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state        <= IDLE;
      chunk        <= 2'd0;
      neuron       <= 4'd0;
      acc          <= '0;
      result       <= '0;
      result_index <= 4'd0;
    end else begin
      state <= state_nx;
      // Fresh neuron: READ entered from IDLE or OUT.
      if (state_nx == READ && state != MAC)
        acc <= '0;
      if (state == MAC) begin
        acc   <= acc_sum;
        chunk <= chunk + 2'd1;
      end
      if (state == OUT)
        neuron <= (neuron == LAST) ? 4'd0 : neuron + 4'd1;
      if (state_nx == OUT) begin
        result       <= result_nx;
        result_index <= neuron;
      end
    end
  end
endmodule
